control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 84 ++++++++
 rtl/control_unit_if.sv | 32 +++
 rtl/cu_decode.sv | 41 ++++
 rtl/control_unit.sv | 195 +++++++++++++++++++
 tb/tb_control_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcode encodings (IR[31:27]),
// ALU operation codes driven on "operation", the FSM state encodings,
// the instruction classes produced by cu_decode, and the bit positions
// inside bus_out_sel and ctl_in.
package cu_pkg;

    // Opcode encodings
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // ALU operation codes
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;

    // FSM state encodings held in the state register
    localparam logic [3:0] S_T0      = 4'd0;
    localparam logic [3:0] S_T1      = 4'd1;
    localparam logic [3:0] S_T2      = 4'd2;
    localparam logic [3:0] S_T3      = 4'd3;
    localparam logic [3:0] S_T4      = 4'd4;
    localparam logic [3:0] S_T5      = 4'd5;
    localparam logic [3:0] S_T6      = 4'd6;
    localparam logic [3:0] S_T7      = 4'd7;
    localparam logic [3:0] S_STOPPED = 4'd8;
    localparam logic [3:0] S_HALT    = 4'd9;

    // Named view of the same encodings, used on the debug state output
    typedef enum logic [3:0] {
        ST_T0 = S_T0, ST_T1 = S_T1, ST_T2 = S_T2, ST_T3 = S_T3,
        ST_T4 = S_T4, ST_T5 = S_T5, ST_T6 = S_T6, ST_T7 = S_T7,
        ST_STOPPED = S_STOPPED, ST_HALT = S_HALT
    } cu_state_e;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST, CLS_BR, CLS_MULDIV, CLS_HALT
    } cu_class_e;

    // bus_out_sel bit positions above the sixteen register outputs
    localparam logic [4:0] BUS_PC     = 5'd16;
    localparam logic [4:0] BUS_ZLO    = 5'd17;
    localparam logic [4:0] BUS_ZHI    = 5'd18;
    localparam logic [4:0] BUS_HI     = 5'd19;
    localparam logic [4:0] BUS_LO     = 5'd20;
    localparam logic [4:0] BUS_MDR    = 5'd21;
    localparam logic [4:0] BUS_INPORT = 5'd22;
    localparam logic [4:0] BUS_C      = 5'd23;

    // ctl_in bit positions: {LOin, HIin, Zin_low, Zin_high, Yin, IRin, MDRin, MARin, PCin}
    localparam logic [3:0] CTL_PC  = 4'd0;
    localparam logic [3:0] CTL_MAR = 4'd1;
    localparam logic [3:0] CTL_MDR = 4'd2;
    localparam logic [3:0] CTL_IR  = 4'd3;
    localparam logic [3:0] CTL_Y   = 4'd4;
    localparam logic [3:0] CTL_ZH  = 4'd5;
    localparam logic [3:0] CTL_ZL  = 4'd6;
    localparam logic [3:0] CTL_HI  = 4'd7;
    localparam logic [3:0] CTL_LO  = 4'd8;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle.
//   IR, CON_FF, Stop           : datapath -> control unit
//   bus_out_sel, reg_in_en,
//   ctl_in, IncPC, Read, Write,
//   BAout, operation, run      : control unit -> datapath
// There is no handshake: every strobe is a level, valid for the whole
// cycle in which the control unit drives it, and the datapath acts on it
// at the next rising Clock.
interface control_unit_if;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;
    logic [23:0] bus_out_sel;
    logic [15:0] reg_in_en;
    logic [8:0]  ctl_in;
    logic        IncPC;
    logic        Read;
    logic        Write;
    logic        BAout;
    logic [3:0]  operation;
    logic        run;

    modport master (
        input  IR, CON_FF, Stop,
        output bus_out_sel, reg_in_en, ctl_in, IncPC, Read, Write, BAout, operation, run
    );

    modport slave (
        output IR, CON_FF, Stop,
        input  bus_out_sel, reg_in_en, ctl_in, IncPC, Read, Write, BAout, operation, run
    );
endinterface

// File: rtl/cu_decode.sv
// Opcode decoder: maps IR[31:27] to an instruction class and ALU operation.
//   opcode_i : instruction opcode
//   class_o  : instruction class steering the T3..T7 sequence
//   alu_op_o : ALU operation presented in T4
// Build option CU_MULDIV_EN: when defined, mul/div decode as CLS_MULDIV;
// otherwise they fall into the default arm and behave as nop.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output cu_class_e  class_o,
    output logic [3:0] alu_op_o
);
    always_comb begin
        class_o  = CLS_NOP;
        alu_op_o = ALU_NONE;
        case (opcode_i)
            OP_ADD:  begin class_o = CLS_RTYPE; alu_op_o = ALU_ADD; end
            OP_SUB:  begin class_o = CLS_RTYPE; alu_op_o = ALU_SUB; end
            OP_AND:  begin class_o = CLS_RTYPE; alu_op_o = ALU_AND; end
            OP_OR:   begin class_o = CLS_RTYPE; alu_op_o = ALU_OR;  end
            OP_SHR:  begin class_o = CLS_RTYPE; alu_op_o = ALU_SHR; end
            OP_SHL:  begin class_o = CLS_RTYPE; alu_op_o = ALU_SHL; end
            OP_ROR:  begin class_o = CLS_RTYPE; alu_op_o = ALU_ROR; end
            OP_ROL:  begin class_o = CLS_RTYPE; alu_op_o = ALU_ROL; end
            OP_ADDI: begin class_o = CLS_IMM;   alu_op_o = ALU_ADD; end
            OP_ANDI: begin class_o = CLS_IMM;   alu_op_o = ALU_AND; end
            OP_ORI:  begin class_o = CLS_IMM;   alu_op_o = ALU_OR;  end
            // Address and branch-target arithmetic are additions
            OP_LD:   begin class_o = CLS_LD;    alu_op_o = ALU_ADD; end
            OP_ST:   begin class_o = CLS_ST;    alu_op_o = ALU_ADD; end
            OP_BR:   begin class_o = CLS_BR;    alu_op_o = ALU_ADD; end
`ifdef CU_MULDIV_EN
            OP_MUL:  begin class_o = CLS_MULDIV; alu_op_o = ALU_MUL; end
            OP_DIV:  begin class_o = CLS_MULDIV; alu_op_o = ALU_DIV; end
`endif
            OP_HALT: class_o = CLS_HALT;
            default: class_o = CLS_NOP;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: a T0..T7 step sequencer with STOPPED and HALT.
//   Clock       : system clock, rising edge
//   clear       : synchronous active-high reset; forces T0 and blanks outputs
//   bus         : control_unit_if.master (IR/CON_FF/Stop in, strobes out)
//   dbg_state_o : current state register, for observation only
// Parameter MEM_WAIT (1..15): cycles each memory step holds Read/Write.
// Build option CU_MULDIV_EN enables the mul/div sequence (see cu_decode).
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic           Clock,
    input  logic           clear,
    control_unit_if.master bus,
    output cu_state_e      dbg_state_o
);
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    logic [3:0] state_q, state_d;
    logic [3:0] wait_q, wait_d;
    cu_class_e  cls;
    logic [3:0] alu_op;
    logic [3:0] ra, rb, rc;
    logic       mem_step, step_done;
    logic [3:0] boundary;
    logic       unused_ir;

    assign ra = bus.IR[26:23];
    assign rb = bus.IR[22:19];
    assign rc = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    cu_decode u_decode (
        .opcode_i (bus.IR[31:27]),
        .class_o  (cls),
        .alu_op_o (alu_op)
    );

    // Steps that talk to memory stretch over MEM_WAIT cycles
    assign mem_step  = (state_q == S_T1) ||
                       (state_q == S_T6 && cls == CLS_LD) ||
                       (state_q == S_T7 && cls == CLS_ST);
    assign step_done = !mem_step || (wait_q == WAIT_LAST);

    // Stop is only looked at when an instruction finishes
    assign boundary = bus.Stop ? S_STOPPED : S_T0;

    always_comb begin
        state_d = state_q;
        wait_d  = (mem_step && !step_done) ? wait_q + 4'd1 : 4'd0;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: if (step_done) state_d = S_T2;
            S_T2: begin
                if (cls == CLS_HALT)     state_d = S_HALT;
                else if (cls == CLS_NOP) state_d = boundary;
                else                     state_d = S_T3;
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls == CLS_LD || cls == CLS_ST || cls == CLS_MULDIV) state_d = S_T6;
                else                                                      state_d = boundary;
            end
            S_T6: begin
                if (step_done) state_d = (cls == CLS_LD || cls == CLS_ST) ? S_T7 : boundary;
            end
            S_T7:      if (step_done) state_d = boundary;
            S_STOPPED: if (!bus.Stop) state_d = S_T0;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_T0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= S_T0;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign dbg_state_o = cu_state_e'(state_q);

    // Strobe decode; clear blanks everything so an aborted store never writes
    always_comb begin
        bus.bus_out_sel = '0;
        bus.reg_in_en   = '0;
        bus.ctl_in      = '0;
        bus.IncPC       = 1'b0;
        bus.Read        = 1'b0;
        bus.Write       = 1'b0;
        bus.BAout       = 1'b0;
        bus.operation   = ALU_NONE;
        bus.run         = 1'b0;
        if (!clear) begin
            bus.run = (state_q != S_STOPPED) && (state_q != S_HALT);
            case (state_q)
                S_T0: begin
                    bus.bus_out_sel[BUS_PC] = 1'b1;
                    bus.ctl_in[CTL_MAR]     = 1'b1;
                    bus.ctl_in[CTL_ZL]      = 1'b1;
                    bus.IncPC               = 1'b1;
                end
                S_T1: begin
                    bus.bus_out_sel[BUS_ZLO] = 1'b1;
                    bus.ctl_in[CTL_PC]       = 1'b1;
                    bus.ctl_in[CTL_MDR]      = 1'b1;
                    bus.Read                 = 1'b1;
                end
                S_T2: begin
                    bus.bus_out_sel[BUS_MDR] = 1'b1;
                    bus.ctl_in[CTL_IR]       = 1'b1;
                end
                S_T3: begin
                    case (cls)
                        CLS_RTYPE, CLS_IMM: bus.bus_out_sel[{1'b0, rb}] = 1'b1;
                        CLS_LD, CLS_ST: begin
                            bus.bus_out_sel[{1'b0, rb}] = 1'b1;
                            bus.BAout = 1'b1;
                        end
                        CLS_BR:     bus.bus_out_sel[BUS_PC] = 1'b1;
                        CLS_MULDIV: bus.bus_out_sel[{1'b0, ra}] = 1'b1;
                        default: ;
                    endcase
                    bus.ctl_in[CTL_Y] = 1'b1;
                end
                S_T4: begin
                    case (cls)
                        CLS_RTYPE: bus.bus_out_sel[{1'b0, rc}] = 1'b1;
                        CLS_MULDIV: begin
                            bus.bus_out_sel[{1'b0, rb}] = 1'b1;
                            bus.ctl_in[CTL_ZH] = 1'b1;
                        end
                        default: bus.bus_out_sel[BUS_C] = 1'b1;
                    endcase
                    bus.ctl_in[CTL_ZL] = 1'b1;
                    bus.operation      = alu_op;
                end
                S_T5: begin
                    case (cls)
                        CLS_RTYPE, CLS_IMM: begin
                            bus.bus_out_sel[BUS_ZLO] = 1'b1;
                            bus.reg_in_en[ra]        = 1'b1;
                        end
                        CLS_LD, CLS_ST: begin
                            bus.bus_out_sel[BUS_ZLO] = 1'b1;
                            bus.ctl_in[CTL_MAR]      = 1'b1;
                        end
                        CLS_BR: if (bus.CON_FF) begin
                            bus.bus_out_sel[BUS_ZLO] = 1'b1;
                            bus.ctl_in[CTL_PC]       = 1'b1;
                        end
                        CLS_MULDIV: begin
                            bus.bus_out_sel[BUS_ZLO] = 1'b1;
                            bus.ctl_in[CTL_LO]       = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        CLS_LD: begin
                            bus.Read            = 1'b1;
                            bus.ctl_in[CTL_MDR] = 1'b1;
                        end
                        CLS_ST: begin
                            bus.bus_out_sel[{1'b0, ra}] = 1'b1;
                            bus.ctl_in[CTL_MDR]         = 1'b1;
                        end
                        CLS_MULDIV: begin
                            bus.bus_out_sel[BUS_ZHI] = 1'b1;
                            bus.ctl_in[CTL_HI]       = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T7: begin
                    case (cls)
                        CLS_LD: begin
                            bus.bus_out_sel[BUS_MDR] = 1'b1;
                            bus.reg_in_en[ra]        = 1'b1;
                        end
                        CLS_ST:  bus.Write = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. Two instances share the clock: dut_a with
// MEM_WAIT=1 and dut_b with MEM_WAIT=3. Only one is active at a time, the
// other is held in clear. The driver pushes the expected strobe vector for
// every cycle it drives; the monitor pops and compares on each falling edge.
// Vector layout: {bus_out_sel, reg_in_en, ctl_in, IncPC, Read, Write, BAout, operation, run}
module tb_control_unit;
  import cu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a = 1'b1, clr_b = 1'b1;
  logic [31:0] ir = '0;
  logic con_ff = 1'b0, stop = 1'b0;
  int sel = 0;

  // values applied at the start of the next driven cycle
  logic [31:0] p_ir = '0;
  logic p_cf = 1'b0, p_stop = 1'b0, p_clr = 1'b1;
  int p_sel = 0;

  control_unit_if bus_a();
  control_unit_if bus_b();
  cu_state_e unused_dbg_a, unused_dbg_b;

  assign bus_a.IR = ir;  assign bus_a.CON_FF = con_ff;  assign bus_a.Stop = stop;
  assign bus_b.IR = ir;  assign bus_b.CON_FF = con_ff;  assign bus_b.Stop = stop;

  control_unit #(.MEM_WAIT(1)) dut_a (.Clock(clk), .clear(clr_a), .bus(bus_a), .dbg_state_o(unused_dbg_a));
  control_unit #(.MEM_WAIT(3)) dut_b (.Clock(clk), .clear(clr_b), .bus(bus_b), .dbg_state_o(unused_dbg_b));

  logic [57:0] act_a, act_b;
  assign act_a = {bus_a.bus_out_sel, bus_a.reg_in_en, bus_a.ctl_in, bus_a.IncPC, bus_a.Read,
                  bus_a.Write, bus_a.BAout, bus_a.operation, bus_a.run};
  assign act_b = {bus_b.bus_out_sel, bus_b.reg_in_en, bus_b.ctl_in, bus_b.IncPC, bus_b.Read,
                  bus_b.Write, bus_b.BAout, bus_b.operation, bus_b.run};

  localparam int B_PC = 16, B_ZLO = 17, B_ZHI = 18, B_MDR = 21, B_C = 23;
  localparam logic [8:0] C_LO = 9'h100, C_HI = 9'h080, C_ZL = 9'h040, C_ZH = 9'h020,
                         C_Y = 9'h010, C_IR = 9'h008, C_MDR = 9'h004, C_MAR = 9'h002, C_PC = 9'h001;
  localparam logic [3:0] F_INC = 4'b1000, F_RD = 4'b0100, F_WR = 4'b0010, F_BA = 4'b0001;

  function automatic logic [57:0] ev(input int bus, input int rin, input logic [8:0] ctl,
                                     input logic [3:0] fl, input logic [3:0] op, input logic run);
    logic [23:0] b;
    logic [15:0] r;
    b = (bus >= 0) ? (24'd1 << bus) : 24'd0;
    r = (rin >= 0) ? (16'd1 << rin) : 16'd0;
    return {b, r, ctl, fl, op, run};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input int ra, input int rb, input int rc);
    return {opc, 4'(ra), 4'(rb), 4'(rc), 15'h0};
  endfunction

  logic [57:0] idle_v;
  assign idle_v = ev(-1, -1, 9'h0, 4'h0, ALU_NONE, 1'b0);

  // scoreboard
  logic [57:0] exp_q[$];
  string tag_q[$];
  string cur_tag = "reset";
  int checks = 0, errors = 0;
  logic [57:0] mon_e, mon_act;
  string mon_t;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_act = (sel == 1) ? act_b : act_a;
      checks++;
      if (mon_act !== mon_e) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h", mon_t, $time, mon_act, mon_e);
      end
    end
  end

  // driver: apply pending inputs just after the edge, then post the expectation
  task automatic cyc(input logic [57:0] e);
    @(posedge clk);
    #1;
    ir = p_ir; con_ff = p_cf; stop = p_stop; sel = p_sel;
    clr_a = (p_sel != 0) ? 1'b1 : p_clr;
    clr_b = (p_sel != 1) ? 1'b1 : p_clr;
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
  endtask

  task automatic clear_cycles(input int n);
    cur_tag = "clear";
    p_clr = 1'b1;
    repeat (n) cyc(idle_v);
    p_clr = 1'b0;
  endtask

  task automatic fetch(input int mw);
    cyc(ev(B_PC, -1, C_MAR | C_ZL, F_INC, ALU_NONE, 1'b1));
    repeat (mw) cyc(ev(B_ZLO, -1, C_PC | C_MDR, F_RD, ALU_NONE, 1'b1));
    cyc(ev(B_MDR, -1, C_IR, 4'h0, ALU_NONE, 1'b1));
  endtask

  task automatic do_alu(input string tag, input logic [4:0] opc, input int ra, input int rb,
                        input int rc, input logic [3:0] alu, input bit imm, input int mw);
    cur_tag = tag;
    p_ir = mk_ir(opc, ra, rb, rc);
    fetch(mw);
    cyc(ev(rb, -1, C_Y, 4'h0, ALU_NONE, 1'b1));
    cyc(ev(imm ? B_C : rc, -1, C_ZL, 4'h0, alu, 1'b1));
    cyc(ev(B_ZLO, ra, 9'h0, 4'h0, ALU_NONE, 1'b1));
  endtask

  // ld/st shared address phase T3..T5
  task automatic addr_phase(input int rb);
    cyc(ev(rb, -1, C_Y, F_BA, ALU_NONE, 1'b1));
    cyc(ev(B_C, -1, C_ZL, 4'h0, ALU_ADD, 1'b1));
    cyc(ev(B_ZLO, -1, C_MAR, 4'h0, ALU_NONE, 1'b1));
  endtask

  task automatic do_ld(input int ra, input int rb, input int mw);
    cur_tag = "ld";
    p_ir = mk_ir(OP_LD, ra, rb, 0);
    fetch(mw);
    addr_phase(rb);
    repeat (mw) cyc(ev(-1, -1, C_MDR, F_RD, ALU_NONE, 1'b1));
    cyc(ev(B_MDR, ra, 9'h0, 4'h0, ALU_NONE, 1'b1));
  endtask

  task automatic do_st(input int ra, input int rb, input int mw, input bit stop_mid);
    cur_tag = "st";
    p_ir = mk_ir(OP_ST, ra, rb, 0);
    fetch(mw);
    addr_phase(rb);
    if (stop_mid) p_stop = 1'b1;
    cyc(ev(ra, -1, C_MDR, 4'h0, ALU_NONE, 1'b1));
    repeat (mw) cyc(ev(-1, -1, 9'h0, F_WR, ALU_NONE, 1'b1));
  endtask

  task automatic do_br(input bit cf);
    cur_tag = cf ? "br_taken" : "br_not_taken";
    p_ir = mk_ir(OP_BR, 5, 0, 0);
    p_cf = cf;
    fetch(1);
    cyc(ev(B_PC, -1, C_Y, 4'h0, ALU_NONE, 1'b1));
    cyc(ev(B_C, -1, C_ZL, 4'h0, ALU_ADD, 1'b1));
    if (cf) cyc(ev(B_ZLO, -1, C_PC, 4'h0, ALU_NONE, 1'b1));
    else    cyc(ev(-1, -1, 9'h0, 4'h0, ALU_NONE, 1'b1));
    p_cf = 1'b0;
  endtask

  task automatic do_muldiv(input logic [4:0] opc, input int ra, input int rb, input logic [3:0] alu);
    cur_tag = "muldiv";
    p_ir = mk_ir(opc, ra, rb, 0);
    fetch(1);
`ifdef CU_MULDIV_EN
    cyc(ev(ra, -1, C_Y, 4'h0, ALU_NONE, 1'b1));
    cyc(ev(rb, -1, C_ZL | C_ZH, 4'h0, alu, 1'b1));
    cyc(ev(B_ZLO, -1, C_LO, 4'h0, ALU_NONE, 1'b1));
    cyc(ev(B_ZHI, -1, C_HI, 4'h0, ALU_NONE, 1'b1));
`else
    if (alu == ALU_NONE) cur_tag = "muldiv_op";
`endif
  endtask

  task automatic do_nop(input string tag, input logic [4:0] opc);
    cur_tag = tag;
    p_ir = mk_ir(opc, 1, 2, 3);
    fetch(1);
  endtask

  initial begin
    // ---- dut_a, MEM_WAIT = 1 ----
    p_sel = 0;
    clear_cycles(2);
    do_alu("add_r3_r1_r2", OP_ADD, 3, 1, 2, ALU_ADD, 1'b0, 1);
    do_alu("sub_r10", OP_SUB, 10, 11, 12, ALU_SUB, 1'b0, 1);
    do_alu("or_r7", OP_OR, 7, 5, 6, ALU_OR, 1'b0, 1);
    do_alu("addi_r4", OP_ADDI, 4, 2, 0, ALU_ADD, 1'b1, 1);
    do_ld(2, 0, 1);
    do_st(1, 2, 1, 1'b0);
    do_br(1'b0);
    do_br(1'b1);
    do_muldiv(OP_MUL, 8, 9, ALU_MUL);
    do_muldiv(OP_DIV, 6, 7, ALU_DIV);
    do_nop("nop", OP_NOP);
    do_nop("undef", 5'b11111);
    do_alu("add_after_nop", OP_ADD, 15, 14, 13, ALU_ADD, 1'b0, 1);
    // Stop raised mid-store: the store finishes, then STOPPED
    do_st(4, 3, 1, 1'b1);
    cur_tag = "stopped";
    repeat (3) cyc(idle_v);
    p_stop = 1'b0;
    cyc(idle_v);
    do_alu("add_resume", OP_ADD, 3, 1, 2, ALU_ADD, 1'b0, 1);
    // clear during a store aborts it before any Write
    cur_tag = "st_abort";
    p_ir = mk_ir(OP_ST, 1, 2, 0);
    fetch(1);
    addr_phase(2);
    clear_cycles(1);
    do_alu("add_after_abort", OP_ADD, 9, 8, 7, ALU_ADD, 1'b0, 1);
    // halt holds until clear
    do_nop("halt_fetch", OP_HALT);
    cur_tag = "halt";
    repeat (20) cyc(idle_v);
    clear_cycles(1);
    do_alu("add_after_halt", OP_ADD, 3, 1, 2, ALU_ADD, 1'b0, 1);

    // ---- dut_b, MEM_WAIT = 3 ----
    p_sel = 1;
    clear_cycles(2);
    do_ld(2, 0, 3);
    do_st(1, 2, 3, 1'b0);
    do_alu("add_mw3", OP_ADD, 3, 1, 2, ALU_ADD, 1'b0, 3);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
